// File: rtl/user_tlp_pkg.sv
// rtl/user_tlp_pkg.sv - shared TLP codes, RC descriptor offsets and decoder state encoding
package user_tlp_pkg;

    localparam int RC_DATA_W  = 128;
    localparam int RC_TUSER_W = 75;

    // fmt/type codes shared with the requester-request encoder
    localparam logic [6:0] TYPE_MEMRD32 = 7'h00;
    localparam logic [6:0] TYPE_MEMWR32 = 7'h40;
    localparam logic [6:0] TYPE_MEMRD64 = 7'h20;
    localparam logic [6:0] TYPE_MEMWR64 = 7'h60;

    localparam int RC_DWCNT_LSB  = 32;
    localparam int RC_DWCNT_W    = 11;
    localparam int RC_STATUS_LSB = 43;
    localparam int RC_POISON_BIT = 46;
    localparam int RC_TAG_LSB    = 64;
    localparam int RC_SOF_BIT    = 32;
    localparam int RC_DISC_BIT   = 42;

    localparam logic [2:0] CPL_SC  = 3'd0;
    localparam logic [2:0] CPL_UR  = 3'd1;
    localparam logic [2:0] CPL_CRS = 3'd2;
    localparam logic [2:0] CPL_CA  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } rx_state_e;

endpackage

// File: rtl/user_tlp_decoder_if.sv
// rtl/user_tlp_decoder_if.sv - AXI-S requester completion stream bundle
interface user_tlp_decoder_if
    import user_tlp_pkg::*;
#(
    parameter int TUSER_W = RC_TUSER_W,
    parameter int DATA_W  = RC_DATA_W,
    parameter int KEEP_W  = DATA_W / 32
);
    logic [DATA_W-1:0]  tdata;
    logic [KEEP_W-1:0]  tkeep;
    logic [TUSER_W-1:0] tuser;
    logic               tlast;
    logic               tvalid;
    logic               tready;

    modport master (output tdata, tkeep, tuser, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/user_tlp_cpl_timer.sv
// rtl/user_tlp_cpl_timer.sv - completion timeout counter with clear, enable and terminal count
module user_tlp_cpl_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    assign tc = (count == LAST);

    // holds at terminal count so a stalled owner never sees a wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !tc) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/user_tlp_decoder.sv
// rtl/user_tlp_decoder.sv - single-DW read completion matcher with timeout and unexpected-completion drain
module user_tlp_decoder
    import user_tlp_pkg::*;
#(
    parameter int AXI4_RC_TUSER_WIDTH = 75,
    parameter int C_DATA_WIDTH        = 128,
    parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32,
    parameter int TIMEOUT_CYCLES      = 1024
) (
    input  logic                     user_clk,
    input  logic                     reset,
    user_tlp_decoder_if.slave        m_axis_rc,
    input  logic                     rx_arm,
    input  logic [7:0]               rx_expect_tag,
    output logic                     rx_done,
    output logic                     rx_timeout,
    output logic [31:0]              rx_data,
    output logic [7:0]               rx_tag,
    output logic [2:0]               rx_status,
    output logic                     rx_err,
    output logic [7:0]               rx_unexp_cnt
);
    rx_state_e state, state_n, ret, ret_n;
    logic       pend, pend_n;
    logic [7:0] exp_tag, tag_n;
    logic       rdy;
    logic       tclr, run, tmr_tc, tc;
    logic       cnt_inc, cap, done_n, to_n;

    logic        beat, sof, last, hit, err_now;
    logic [7:0]  b_tag;
    logic [2:0]  b_status;
    logic [10:0] b_dwcnt;
    logic        unused_ok;

    assign m_axis_rc.tready = rdy;
    assign beat     = m_axis_rc.tvalid & rdy;
    assign sof      = beat & m_axis_rc.tuser[RC_SOF_BIT];
    assign last     = m_axis_rc.tlast;
    assign b_tag    = m_axis_rc.tdata[RC_TAG_LSB +: 8];
    assign b_status = m_axis_rc.tdata[RC_STATUS_LSB +: 3];
    assign b_dwcnt  = m_axis_rc.tdata[RC_DWCNT_LSB +: RC_DWCNT_W];
    assign hit      = (b_tag == exp_tag);
    assign err_now  = (b_status != CPL_SC) | m_axis_rc.tdata[RC_POISON_BIT]
                    | m_axis_rc.tuser[RC_DISC_BIT] | (b_dwcnt != 11'd1)
                    | !m_axis_rc.tkeep[KEEP_WIDTH-1] | !last;

    assign unused_ok = ^{m_axis_rc.tdata[95:72], m_axis_rc.tdata[63:47], m_axis_rc.tdata[31:0],
                         m_axis_rc.tuser[AXI4_RC_TUSER_WIDTH-1:43], m_axis_rc.tuser[41:33],
                         m_axis_rc.tuser[31:0], m_axis_rc.tkeep[KEEP_WIDTH-2:0]};

    // the timer also runs while draining a stray packet on behalf of an armed request
    assign run = (state == ST_WAIT) || (state == ST_DRAIN && ret == ST_WAIT && !pend);
    assign tc  = tmr_tc & run;

    user_tlp_cpl_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk    (user_clk),
        .reset  (reset),
        .clear  (tclr),
        .enable (run),
        .tc     (tmr_tc)
    );

    always_comb begin
        state_n = state;
        ret_n   = ret;
        pend_n  = pend;
        tag_n   = exp_tag;
        tclr    = 1'b0;
        cnt_inc = 1'b0;
        cap     = 1'b0;
        done_n  = 1'b0;
        to_n    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sof) begin
                    cnt_inc = 1'b1;
                    if (!last) begin
                        state_n = ST_DRAIN;
                        ret_n   = ST_IDLE;
                    end
                end
            end
            ST_WAIT: begin
                if (sof && hit) begin
                    cap     = 1'b1;
                    done_n  = 1'b1;
                    state_n = last ? ST_IDLE : ST_DRAIN;
                    ret_n   = ST_IDLE;
                end else begin
                    if (sof) begin
                        cnt_inc = 1'b1;
                        if (!last) begin
                            state_n = ST_DRAIN;
                            ret_n   = ST_WAIT;
                        end
                    end
                    if (tc) begin
                        to_n = 1'b1;
                        if (state_n == ST_DRAIN) ret_n = ST_IDLE;
                        else                     state_n = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (rx_arm) begin
                    pend_n = 1'b1;
                end else if (tc) begin
                    to_n  = 1'b1;
                    ret_n = ST_IDLE;
                end
                if (beat && last) begin
                    if (pend_n) begin
                        state_n = ST_WAIT;
                        pend_n  = 1'b0;
                        tclr    = 1'b1;
                    end else begin
                        state_n = ret_n;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
        // a new arm supersedes the old request, including a timeout due this cycle
        if (rx_arm) begin
            tag_n = rx_expect_tag;
            if (state != ST_DRAIN) begin
                state_n = ST_WAIT;
                ret_n   = ST_IDLE;
                pend_n  = 1'b0;
                tclr    = 1'b1;
                to_n    = 1'b0;
            end
        end
    end

    always_ff @(posedge user_clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            ret          <= ST_IDLE;
            pend         <= 1'b0;
            exp_tag      <= '0;
            rdy          <= 1'b0;
            rx_done      <= 1'b0;
            rx_timeout   <= 1'b0;
            rx_data      <= '0;
            rx_tag       <= '0;
            rx_status    <= '0;
            rx_err       <= 1'b0;
            rx_unexp_cnt <= '0;
        end else begin
            state      <= state_n;
            ret        <= ret_n;
            pend       <= pend_n;
            exp_tag    <= tag_n;
            rdy        <= 1'b1;
            rx_done    <= done_n;
            rx_timeout <= to_n;
            if (cap) begin
                rx_data   <= m_axis_rc.tdata[C_DATA_WIDTH-1 -: 32];
                rx_tag    <= b_tag;
                rx_status <= b_status;
                rx_err    <= err_now;
            end
            if (cnt_inc && rx_unexp_cnt != 8'hFF) begin
                rx_unexp_cnt <= rx_unexp_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_user_tlp_decoder.sv
// tb/tb_user_tlp_decoder.sv - scoreboard bench for the RC completion decoder
module tb_user_tlp_decoder;
    localparam int T = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_arm = 1'b0;
    logic [7:0]  rx_expect_tag = 8'h00;
    logic        rx_done, rx_timeout, rx_err;
    logic [31:0] rx_data;
    logic [7:0]  rx_tag, rx_unexp_cnt;
    logic [2:0]  rx_status;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  tag;
        logic [2:0]  status;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    user_tlp_decoder_if #(.TUSER_W(75), .DATA_W(128)) rc_if ();

    user_tlp_decoder #(
        .AXI4_RC_TUSER_WIDTH(75), .C_DATA_WIDTH(128), .KEEP_WIDTH(4), .TIMEOUT_CYCLES(T)
    ) dut (
        .user_clk     (clk),
        .reset        (reset),
        .m_axis_rc    (rc_if),
        .rx_arm       (rx_arm),
        .rx_expect_tag(rx_expect_tag),
        .rx_done      (rx_done),
        .rx_timeout   (rx_timeout),
        .rx_data      (rx_data),
        .rx_tag       (rx_tag),
        .rx_status    (rx_status),
        .rx_err       (rx_err),
        .rx_unexp_cnt (rx_unexp_cnt)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        rc_if.tvalid = 1'b0;
        rc_if.tdata  = '0;
        rc_if.tuser  = '0;
        rc_if.tkeep  = '0;
        rc_if.tlast  = 1'b0;
    endtask

    task automatic set_beat(input logic sof, input logic [7:0] tag, input logic [2:0] st,
                            input logic poison, input logic disc, input logic [10:0] dwc,
                            input logic [31:0] dw3, input logic [3:0] keep, input logic last);
        rc_if.tdata          = '0;
        rc_if.tdata[31:0]    = $urandom;
        rc_if.tdata[127:96]  = dw3;
        rc_if.tdata[71:64]   = tag;
        rc_if.tdata[46]      = poison;
        rc_if.tdata[45:43]   = st;
        rc_if.tdata[42:32]   = dwc;
        rc_if.tuser          = '0;
        rc_if.tuser[32]      = sof;
        rc_if.tuser[42]      = disc;
        rc_if.tkeep          = keep;
        rc_if.tlast          = last;
        rc_if.tvalid         = 1'b1;
    endtask

    task automatic send(input logic sof, input logic [7:0] tag, input logic [2:0] st,
                        input logic poison, input logic disc, input logic [10:0] dwc,
                        input logic [31:0] dw3, input logic [3:0] keep, input logic last);
        set_beat(sof, tag, st, poison, disc, dwc, dw3, keep, last);
        cyc();
        bus_idle();
    endtask

    task automatic arm(input logic [7:0] tag);
        rx_arm = 1'b1;
        rx_expect_tag = tag;
        cyc();
        rx_arm = 1'b0;
    endtask

    task automatic test_reset();
        bus_idle();
        reset = 1'b1;
        cyc();
        cyc();
        total++;
        if ({rc_if.tready, rx_done, rx_timeout, rx_data, rx_tag, rx_status, rx_err, rx_unexp_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%0b done=%0b to=%0b data=%h cnt=%0d want all 0",
                     rc_if.tready, rx_done, rx_timeout, rx_data, rx_unexp_cnt);
        end
        reset = 1'b0;
        cyc();
        total++;
        if (rc_if.tready !== 1'b1) begin
            bad++;
            $display("FAIL reset_tready: got %0b want 1", rc_if.tready);
        end
    endtask

    task automatic test_single();
        exp_t e;
        arm(8'h05);
        sb.push_back('{32'hDEADBEEF, 8'h05, 3'd0, 1'b0});
        send(1, 8'h05, 3'd0, 0, 0, 11'd1, 32'hDEADBEEF, 4'hF, 1);
        total++;
        if (rx_done !== 1'b1 || sb.size() == 0) begin
            bad++;
            $display("FAIL single_done: got %0b want 1", rx_done);
        end else begin
            e = sb.pop_front();
            total++;
            if ({rx_data, rx_tag, rx_status, rx_err} !== {e.data, e.tag, e.status, e.err}) begin
                bad++;
                $display("FAIL single_fields: got %h/%h/%0d/%0b want %h/%h/%0d/%0b",
                         rx_data, rx_tag, rx_status, rx_err, e.data, e.tag, e.status, e.err);
            end
        end
        cyc();
        total++;
        if (rx_done !== 1'b0 || rx_data !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL single_hold: got done=%0b data=%h want 0/deadbeef", rx_done, rx_data);
        end
        send(1, 8'h05, 3'd0, 0, 0, 11'd1, 32'h1, 4'hF, 1);
        exp_cnt++;
        total++;
        if (rx_done !== 1'b0 || rx_unexp_cnt !== 8'(exp_cnt)) begin
            bad++;
            $display("FAIL single_idle_after: got done=%0b cnt=%0d want 0/%0d", rx_done, rx_unexp_cnt, exp_cnt);
        end
    endtask

    task automatic test_timeout();
        int seen = -1;
        int pulses = 0;
        bit saw_done = 0;
        arm(8'h07);
        for (int k = 1; k <= T + 3; k++) begin
            cyc();
            if (rx_timeout) begin
                pulses++;
                if (seen < 0) seen = k;
            end
            if (rx_done) saw_done = 1;
        end
        total++;
        if (seen != T || pulses != 1) begin
            bad++;
            $display("FAIL timeout_edge: got first=%0d pulses=%0d want %0d/1", seen, pulses, T);
        end
        total++;
        if (saw_done) begin
            bad++;
            $display("FAIL timeout_no_done: got done=1 want 0");
        end
        send(1, 8'h07, 3'd0, 0, 0, 11'd1, 32'h77, 4'hF, 1);
        exp_cnt++;
        total++;
        if (rx_done !== 1'b0 || rx_unexp_cnt !== 8'(exp_cnt)) begin
            bad++;
            $display("FAIL timeout_late_beat: got done=%0b cnt=%0d want 0/%0d", rx_done, rx_unexp_cnt, exp_cnt);
        end
    endtask

    task automatic test_mismatch();
        exp_t e;
        arm(8'h10);
        send(1, 8'h11, 3'd0, 0, 0, 11'd1, 32'h11111111, 4'hF, 1);
        exp_cnt++;
        total++;
        if (rx_done !== 1'b0 || rx_unexp_cnt !== 8'(exp_cnt)) begin
            bad++;
            $display("FAIL mismatch_count: got done=%0b cnt=%0d want 0/%0d", rx_done, rx_unexp_cnt, exp_cnt);
        end
        sb.push_back('{32'h12345678, 8'h10, 3'd1, 1'b1});
        send(1, 8'h10, 3'd1, 0, 0, 11'd1, 32'h12345678, 4'hF, 1);
        total++;
        if (rx_done !== 1'b1 || sb.size() == 0) begin
            bad++;
            $display("FAIL mismatch_done: got %0b want 1", rx_done);
        end else begin
            e = sb.pop_front();
            total++;
            if ({rx_data, rx_tag, rx_status, rx_err} !== {e.data, e.tag, e.status, e.err}) begin
                bad++;
                $display("FAIL mismatch_fields: got %h/%h/%0d/%0b want %h/%h/%0d/%0b",
                         rx_data, rx_tag, rx_status, rx_err, e.data, e.tag, e.status, e.err);
            end
        end
    endtask

    task automatic test_multibeat();
        exp_t e;
        arm(8'h20);
        sb.push_back('{32'hA5A5A5A5, 8'h20, 3'd0, 1'b1});
        send(1, 8'h20, 3'd0, 0, 0, 11'd3, 32'hA5A5A5A5, 4'hF, 0);
        total++;
        if (rx_done !== 1'b1 || sb.size() == 0) begin
            bad++;
            $display("FAIL multibeat_done: got %0b want 1", rx_done);
        end else begin
            e = sb.pop_front();
            total++;
            if ({rx_data, rx_tag, rx_status, rx_err} !== {e.data, e.tag, e.status, e.err}) begin
                bad++;
                $display("FAIL multibeat_fields: got %h/%h/%0d/%0b want %h/%h/%0d/%0b",
                         rx_data, rx_tag, rx_status, rx_err, e.data, e.tag, e.status, e.err);
            end
        end
        send(0, 8'h20, 3'd0, 0, 0, 11'd3, 32'hB0B0B0B0, 4'hF, 0);
        // sof bit on the final beat must still be swallowed by the drain
        send(1, 8'h20, 3'd0, 0, 0, 11'd1, 32'hC0C0C0C0, 4'hF, 1);
        total++;
        if (rx_done !== 1'b0 || rx_unexp_cnt !== 8'(exp_cnt) || rx_data !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL multibeat_drain: got done=%0b cnt=%0d data=%h want 0/%0d/a5a5a5a5",
                     rx_done, rx_unexp_cnt, rx_data, exp_cnt);
        end
        send(1, 8'h20, 3'd0, 0, 0, 11'd1, 32'hD0D0D0D0, 4'hF, 1);
        exp_cnt++;
        total++;
        if (rx_done !== 1'b0 || rx_unexp_cnt !== 8'(exp_cnt)) begin
            bad++;
            $display("FAIL multibeat_next_sof: got done=%0b cnt=%0d want 0/%0d", rx_done, rx_unexp_cnt, exp_cnt);
        end
    endtask

    task automatic test_err_flags();
        exp_t e;
        logic [2:0] st;
        logic       poison, disc;
        logic [3:0] keep;
        for (int i = 0; i < 5; i++) begin
            st = 3'd0; poison = 0; disc = 0; keep = 4'hF;
            case (i)
                0: disc = 1;
                1: keep = 4'h7;
                2: poison = 1;
                3: st = 3'd4;
                default: ;
            endcase
            arm(8'h70 + 8'(i));
            sb.push_back('{32'h0BAD0000 + 32'(i), 8'h70 + 8'(i), st, (i != 4)});
            send(1, 8'h70 + 8'(i), st, poison, disc, 11'd1, 32'h0BAD0000 + 32'(i), keep, 1);
            total++;
            if (rx_done !== 1'b1 || sb.size() == 0) begin
                bad++;
                $display("FAIL err_flags_done[%0d]: got %0b want 1", i, rx_done);
            end else begin
                e = sb.pop_front();
                if ({rx_data, rx_tag, rx_status, rx_err} !== {e.data, e.tag, e.status, e.err}) begin
                    bad++;
                    $display("FAIL err_flags_fields[%0d]: got %h/%h/%0d/%0b want %h/%h/%0d/%0b", i,
                             rx_data, rx_tag, rx_status, rx_err, e.data, e.tag, e.status, e.err);
                end
            end
        end
    endtask

    task automatic test_arm_in_drain();
        exp_t e;
        send(1, 8'h61, 3'd0, 0, 0, 11'd2, 32'h6161, 4'hF, 0);
        exp_cnt++;
        set_beat(0, 8'h00, 3'd0, 0, 0, 11'd0, 32'h0, 4'hF, 0);
        rx_arm = 1'b1;
        rx_expect_tag = 8'h60;
        cyc();
        rx_arm = 1'b0;
        bus_idle();
        send(0, 8'h60, 3'd0, 0, 0, 11'd1, 32'h6060, 4'hF, 1);
        sb.push_back('{32'h60606060, 8'h60, 3'd0, 1'b0});
        send(1, 8'h60, 3'd0, 0, 0, 11'd1, 32'h60606060, 4'hF, 1);
        total++;
        if (rx_done !== 1'b1 || sb.size() == 0 || rx_unexp_cnt !== 8'(exp_cnt)) begin
            bad++;
            $display("FAIL arm_in_drain: got done=%0b cnt=%0d want 1/%0d", rx_done, rx_unexp_cnt, exp_cnt);
        end else begin
            e = sb.pop_front();
            if ({rx_data, rx_tag} !== {e.data, e.tag}) begin
                bad++;
                $display("FAIL arm_in_drain_fields: got %h/%h want %h/%h", rx_data, rx_tag, e.data, e.tag);
            end
        end
    endtask

    task automatic test_rearm();
        exp_t e;
        int seen = -1;
        int pulses = 0;
        arm(8'h30);
        for (int k = 1; k <= 2100; k++) begin
            if (k == 1000) begin
                rx_arm = 1'b1;
                rx_expect_tag = 8'h31;
            end
            cyc();
            rx_arm = 1'b0;
            if (rx_timeout) begin
                pulses++;
                if (seen < 0) seen = k;
            end
        end
        total++;
        if (seen != 1000 + T || pulses != 1) begin
            bad++;
            $display("FAIL rearm_timeout: got first=%0d pulses=%0d want %0d/1", seen, pulses, 1000 + T);
        end
        arm(8'h40);
        repeat (T - 1) cyc();
        sb.push_back('{32'h40404040, 8'h40, 3'd0, 1'b0});
        send(1, 8'h40, 3'd0, 0, 0, 11'd1, 32'h40404040, 4'hF, 1);
        total++;
        if (rx_done !== 1'b1 || rx_timeout !== 1'b0 || sb.size() == 0) begin
            bad++;
            $display("FAIL terminal_beat: got done=%0b to=%0b want 1/0", rx_done, rx_timeout);
        end else begin
            e = sb.pop_front();
            if (rx_data !== e.data) begin
                bad++;
                $display("FAIL terminal_beat_data: got %h want %h", rx_data, e.data);
            end
        end
        pulses = 0;
        repeat (5) begin
            cyc();
            if (rx_timeout) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL terminal_no_timeout: got %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) begin
            set_beat(1, 8'h99, 3'd0, 0, 0, 11'd1, 32'(i), 4'hF, 1);
            cyc();
            if (exp_cnt < 255) exp_cnt++;
            if (exp_cnt == 128) begin
                total++;
                if (rx_unexp_cnt !== 8'd128) begin
                    bad++;
                    $display("FAIL saturate_mid: got %0d want 128", rx_unexp_cnt);
                end
            end
        end
        bus_idle();
        total++;
        if (rx_unexp_cnt !== 8'(exp_cnt) || exp_cnt != 255) begin
            bad++;
            $display("FAIL saturate_end: got %0d want 255", rx_unexp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        arm(8'h50);
        send(1, 8'h51, 3'd0, 0, 0, 11'd4, 32'h5151, 4'hF, 0);
        set_beat(0, 8'h50, 3'd0, 0, 0, 11'd1, 32'h5050, 4'hF, 0);
        reset = 1'b1;
        cyc();
        cyc();
        exp_cnt = 0;
        total++;
        if ({rc_if.tready, rx_done, rx_timeout, rx_data, rx_tag, rx_status, rx_err, rx_unexp_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got rdy=%0b data=%h tag=%h cnt=%0d want all 0",
                     rc_if.tready, rx_data, rx_tag, rx_unexp_cnt);
        end
        reset = 1'b0;
        cyc();
        send(0, 8'h50, 3'd0, 0, 0, 11'd1, 32'h5050, 4'hF, 1);
        send(0, 8'h50, 3'd0, 0, 0, 11'd1, 32'h5050, 4'hF, 0);
        total++;
        if (rx_done !== 1'b0 || rx_unexp_cnt !== 8'(exp_cnt)) begin
            bad++;
            $display("FAIL reset_mid_nonsof: got done=%0b cnt=%0d want 0/%0d", rx_done, rx_unexp_cnt, exp_cnt);
        end
        send(1, 8'h50, 3'd0, 0, 0, 11'd1, 32'h5050, 4'hF, 1);
        exp_cnt++;
        total++;
        if (rx_done !== 1'b0 || rx_unexp_cnt !== 8'(exp_cnt)) begin
            bad++;
            $display("FAIL reset_mid_sof: got done=%0b cnt=%0d want 0/%0d", rx_done, rx_unexp_cnt, exp_cnt);
        end
        repeat (T + 20) begin
            cyc();
            if (rx_timeout) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL reset_mid_no_timeout: got %0d pulses want 0", pulses);
        end
    endtask

    initial begin
        bus_idle();
        test_reset();
        test_single();
        test_timeout();
        test_mismatch();
        test_multibeat();
        test_err_flags();
        test_arm_in_drain();
        test_rearm();
        test_saturate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
